// File: rtl/multicore_pkg.sv
// multicore_pkg
//   Definitions shared by the dispatch scheduler and the cores it feeds:
//   array geometry, instruction layout, scheduler state encoding and the
//   opcode map carried in instruction bits [11:8].
//   Optional feature macro used by the scheduler: DISPATCH_STATS_EN.
package multicore_pkg;

    localparam int NUM_CORES        = 4;
    localparam int INSTR_W          = 12;   // [11:8] opcode, [7:4] A, [3:0] B
    localparam int CNT_W            = 3;
    localparam int FIFO_FULL        = 7;
    localparam int IDLE_GATE_CYCLES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_LS  = 4'h6;
    localparam logic [3:0] OP_RS  = 4'h7;

endpackage

// File: rtl/core_select.sv
// core_select
//   Combinational picker: among eligible cores, choose the one with the
//   smallest occupancy; ties go to the first candidate met when scanning
//   upward from rr_ptr with wrap-around.
// Ports:
//   counts       in  N*CW  per-core occupancy, core i at [i*CW +: CW]
//   eligible     in  N     cores allowed to receive a write
//   rr_ptr       in  PTR_W tie-break scan start
//   winner       out N     one-hot chosen core (all zero if none eligible)
//   any_eligible out 1     at least one core eligible
import multicore_pkg::*;

module core_select #(
    parameter int N     = NUM_CORES,
    parameter int CW    = CNT_W,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*CW-1:0] counts,
    input  logic [N-1:0]    eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]    winner,
    output logic            any_eligible
);

    logic [CW-1:0]    cnt_arr [N];
    logic             found;
    logic [CW-1:0]    best;
    logic [PTR_W-1:0] best_idx;
    logic [PTR_W-1:0] idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign cnt_arr[gi] = counts[gi*CW +: CW];
        end
    endgenerate

    assign any_eligible = |eligible;

    // Strict '<' keeps the earliest candidate in scan order on a tie.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        best     = '0;
        best_idx = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N);
            if (eligible[idx] && (!found || cnt_arr[idx] < best)) begin
                found    = 1'b1;
                best     = cnt_arr[idx];
                best_idx = idx;
            end
        end
        winner[best_idx] = found;
    end

endmodule

// File: rtl/core_dispatch_sched.sv
// core_dispatch_sched
//   Steers a single valid/ready instruction stream into one of NUM_CORES
//   core FIFOs (least occupied, round-robin tie-break), gates idle cores'
//   clocks, and runs a flush/drain handshake.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_instr/in_ready   instruction input handshake (in_ready comb)
//   flush          request drain of all cores
//   core_count     per-core FIFO occupancy, core i at [i*CNT_W +: CNT_W]
//   core_empty     per-core FIFO empty flags
//   core_wr_en     one-hot write strobe, core_instr broadcast payload
//   clock_disable  per-core clock gating request
//   pending_total  registered sum of core_count
//   sched_state    RUN/STALL/DRAIN/DONE, drained = in DONE
// Optional feature macro DISPATCH_STATS_EN adds stat_dispatch (per-core
// saturating write counts, 16 bits each) and stat_stall (cycles with
// in_valid high while in_ready low).
import multicore_pkg::*;

module core_dispatch_sched #(
    parameter int NUM_CORES        = multicore_pkg::NUM_CORES,
    parameter int INSTR_W          = multicore_pkg::INSTR_W,
    parameter int CNT_W            = multicore_pkg::CNT_W,
    parameter int FIFO_FULL        = multicore_pkg::FIFO_FULL,
    parameter int IDLE_GATE_CYCLES = multicore_pkg::IDLE_GATE_CYCLES,
    parameter int TOT_W            = $clog2(NUM_CORES*FIFO_FULL+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic [NUM_CORES*CNT_W-1:0] core_count,
    input  logic [NUM_CORES-1:0]       core_empty,
    output logic [NUM_CORES-1:0]       core_wr_en,
    output logic [INSTR_W-1:0]         core_instr,
    output logic [NUM_CORES-1:0]       clock_disable,
    output logic [TOT_W-1:0]           pending_total,
    output logic [1:0]                 sched_state,
    output logic                       drained
`ifdef DISPATCH_STATS_EN
    ,
    output logic [NUM_CORES*16-1:0]    stat_dispatch,
    output logic [15:0]                stat_stall
`endif
);

    localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int IDLE_W = $clog2(IDLE_GATE_CYCLES+1);
    localparam logic [CNT_W:0]    FULL_V   = (CNT_W+1)'(FIFO_FULL);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_GATE_CYCLES);

    sched_state_t         state_reg, state_next;
    logic [NUM_CORES-1:0] wr_en_reg;
    logic [INSTR_W-1:0]   instr_reg;
    logic [TOT_W-1:0]     total_reg, total_next;
    logic                 drained_reg;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next, win_idx;
    logic [NUM_CORES-1:0] eligible, winner;
    logic                 any_eligible, transfer;

    // A write already in flight counts against the FIFO because the
    // external core_count has not yet seen it.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_elig
            assign eligible[gi] = ({1'b0, core_count[gi*CNT_W +: CNT_W]}
                                  + {{CNT_W{1'b0}}, wr_en_reg[gi]}) < FULL_V;
        end
    endgenerate

    core_select #(.N(NUM_CORES), .CW(CNT_W), .PTR_W(PTR_W)) u_select (
        .counts       (core_count),
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_reg),
        .winner       (winner),
        .any_eligible (any_eligible)
    );

    assign in_ready = (state_reg == RUN) && any_eligible;
    assign transfer = in_valid && in_ready;

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (winner[k]) win_idx = PTR_W'(k);
        end
        rr_ptr_next = (win_idx == PTR_W'(NUM_CORES-1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        total_next = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            total_next = total_next + TOT_W'(core_count[k*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (flush) state_next = DRAIN;
                     else if (!any_eligible) state_next = STALL;
            STALL:   if (flush) state_next = DRAIN;
                     else if (any_eligible) state_next = RUN;
            DRAIN:   if ((&core_empty) && (wr_en_reg == '0)) state_next = DONE;
            DONE:    if (!flush) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            wr_en_reg   <= '0;
            instr_reg   <= '0;
            total_reg   <= '0;
            drained_reg <= 1'b0;
            rr_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            wr_en_reg   <= transfer ? winner : '0;
            total_reg   <= total_next;
            drained_reg <= (state_next == DONE);
            if (transfer) begin
                instr_reg  <= in_instr;
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    // Idle gating: the register follows idle_next so that a dispatch
    // clears clock_disable on the same edge its write strobe rises.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_idle
            logic [IDLE_W-1:0] idle_cnt_reg, idle_next;
            logic              idle_hit, cd_reg;

            assign idle_hit  = core_empty[gi] && !wr_en_reg[gi]
                               && !(transfer && winner[gi]);
            assign idle_next = !idle_hit ? '0 :
                               (idle_cnt_reg == IDLE_MAX) ? IDLE_MAX :
                               idle_cnt_reg + 1'b1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    idle_cnt_reg <= '0;
                    cd_reg       <= 1'b0;
                end else begin
                    idle_cnt_reg <= idle_next;
                    cd_reg       <= (idle_next == IDLE_MAX) && (state_next != DRAIN);
                end
            end

            assign clock_disable[gi] = cd_reg;
        end
    endgenerate

`ifdef DISPATCH_STATS_EN
    logic [15:0] stall_reg;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_stat
            logic [15:0] disp_reg;
            always_ff @(posedge clk) begin
                if (rst) disp_reg <= '0;
                else if (transfer && winner[gi] && disp_reg != 16'hFFFF)
                    disp_reg <= disp_reg + 16'd1;
            end
            assign stat_dispatch[gi*16 +: 16] = disp_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) stall_reg <= '0;
        else if (in_valid && !in_ready && stall_reg != 16'hFFFF)
            stall_reg <= stall_reg + 16'd1;
    end

    assign stat_stall = stall_reg;
`endif

    assign core_wr_en    = wr_en_reg;
    assign core_instr    = instr_reg;
    assign pending_total = total_reg;
    assign sched_state   = state_reg;
    assign drained       = drained_reg;

endmodule

// File: tb/tb_core_dispatch_sched.sv
// Testbench for core_dispatch_sched. Expected writes are queued when an
// instruction is offered and checked by a monitor when the strobe appears.
module tb_core_dispatch_sched;

    localparam int N  = 4;
    localparam int IW = 12;
    localparam int CW = 3;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          flush;
    logic [N*CW-1:0] core_count;
    logic [N-1:0]  core_empty;
    logic [N-1:0]  core_wr_en;
    logic [IW-1:0] core_instr;
    logic [N-1:0]  clock_disable;
    logic [TW-1:0] pending_total;
    logic [1:0]    sched_state;
    logic          drained;
`ifdef DISPATCH_STATS_EN
    logic [N*16-1:0] stat_dispatch;
    logic [15:0]     stat_stall;
`endif

    core_dispatch_sched dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .flush         (flush),
        .core_count    (core_count),
        .core_empty    (core_empty),
        .core_wr_en    (core_wr_en),
        .core_instr    (core_instr),
        .clock_disable (clock_disable),
        .pending_total (pending_total),
        .sched_state   (sched_state),
        .drained       (drained)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_dispatch (stat_dispatch),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  wr;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // Monitor: every write strobe must match the oldest expected dispatch.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mon_en && core_wr_en !== '0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got wr_en=%b instr=%h, required none", core_wr_en, core_instr);
            end else begin
                e = sb.pop_front();
                if (core_wr_en !== e.wr || core_instr !== e.instr) begin
                    miscompares++;
                    $display("FAIL dispatch: got wr_en=%b instr=%h, required wr_en=%b instr=%h",
                             core_wr_en, core_instr, e.wr, e.instr);
                end else begin
                    $display("dispatch wr_en=%b instr=%h ok", core_wr_en, core_instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        core_count = '0; core_empty = '0;
        tick(); tick();
        vectors++;
        if (core_wr_en !== 4'b0 || core_instr !== 12'h0 || clock_disable !== 4'b0 ||
            pending_total !== 5'd0 || sched_state !== 2'd0 || drained !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got wr=%b instr=%h cd=%b tot=%0d st=%0d dr=%b, required all zero",
                     core_wr_en, core_instr, clock_disable, pending_total, sched_state, drained);
        end else $display("reset state ok");
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = 12'h123;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready: got %b, required 1", in_ready);
            end
            sb.push_back('{wr: 4'(1 << k), instr: 12'h123});
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_tie_break();
        core_count = {3'd5, 3'd1, 3'd1, 3'd3};
        in_valid = 1'b1; in_instr = 12'h2A5;
        sb.push_back('{wr: 4'b0010, instr: 12'h2A5});
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (pending_total !== 5'd10) begin
            miscompares++;
            $display("FAIL pending_total: got %0d, required 10", pending_total);
        end else $display("pending_total=%0d ok", pending_total);
        in_valid = 1'b1; in_instr = 12'h3B6;
        sb.push_back('{wr: 4'b0100, instr: 12'h3B6});
        tick();
        in_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_stall();
        core_count = {3'd7, 3'd7, 3'd7, 3'd7};
        in_valid = 1'b1; in_instr = 12'h456;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got %b, required 0", in_ready);
        end
        tick();
        vectors++;
        if (sched_state !== 2'd1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_state: got st=%0d rdy=%b, required st=1 rdy=0", sched_state, in_ready);
        end else $display("stall state ok");
        core_count = {3'd7, 3'd7, 3'd6, 3'd7};
        tick();
        vectors++;
        if (sched_state !== 2'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_exit: got st=%0d rdy=%b, required st=0 rdy=1", sched_state, in_ready);
        end else $display("stall exit ok");
        sb.push_back('{wr: 4'b0010, instr: 12'h456});
        tick();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL inflight_ready: got %b, required 0", in_ready);
        end else $display("in-flight write blocks core1 ok");
        in_valid = 1'b0;
        tick(); tick();
        core_count = '0;
        tick();
    endtask

    task automatic test_idle_gate();
        core_count = {3'd3, 3'd0, 3'd3, 3'd3};
        core_empty = 4'b0100;
        tick(); tick(); tick();
        vectors++;
        if (clock_disable !== 4'b0000) begin
            miscompares++;
            $display("FAIL gate_early: got %b, required 0000", clock_disable);
        end
        tick();
        vectors++;
        if (clock_disable !== 4'b0100) begin
            miscompares++;
            $display("FAIL gate_on: got %b, required 0100", clock_disable);
        end else $display("clock_disable[2] asserted ok");
        in_valid = 1'b1; in_instr = 12'h7C1;
        sb.push_back('{wr: 4'b0100, instr: 12'h7C1});
        tick();
        in_valid = 1'b0;
        vectors++;
        if (clock_disable !== 4'b0000 || core_wr_en !== 4'b0100) begin
            miscompares++;
            $display("FAIL gate_off: got cd=%b wr=%b, required cd=0000 wr=0100", clock_disable, core_wr_en);
        end else $display("clock_disable released with write ok");
        tick();
    endtask

    task automatic test_flush();
        core_count = {3'd2, 3'd0, 3'd0, 3'd1};
        core_empty = 4'b0110;
        flush = 1'b1;
        tick();
        vectors++;
        if (sched_state !== 2'd2 || in_ready !== 1'b0 || drained !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_enter: got st=%0d rdy=%b dr=%b, required st=2 rdy=0 dr=0",
                     sched_state, in_ready, drained);
        end else $display("drain entered ok");
        tick();
        vectors++;
        if (pending_total !== 5'd3) begin
            miscompares++;
            $display("FAIL drain_total: got %0d, required 3", pending_total);
        end
        tick(); tick(); tick(); tick();
        vectors++;
        if (sched_state !== 2'd2 || clock_disable !== 4'b0000) begin
            miscompares++;
            $display("FAIL drain_hold: got st=%0d cd=%b, required st=2 cd=0000", sched_state, clock_disable);
        end
        core_count = '0;
        core_empty = 4'b1111;
        tick();
        vectors++;
        if (sched_state !== 2'd3 || drained !== 1'b1) begin
            miscompares++;
            $display("FAIL done: got st=%0d dr=%b, required st=3 dr=1", sched_state, drained);
        end else $display("drained ok");
        flush = 1'b0;
        tick();
        vectors++;
        if (sched_state !== 2'd0 || drained !== 1'b0) begin
            miscompares++;
            $display("FAIL done_exit: got st=%0d dr=%b, required st=0 dr=0", sched_state, drained);
        end else $display("back to run ok");
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        core_empty = 4'b0000;
        in_valid = 1'b1; in_instr = 12'h9EF;
        rst = 1'b1;
        tick();
        vectors++;
        if (core_wr_en !== 4'b0 || core_instr !== 12'h0 || clock_disable !== 4'b0 ||
            pending_total !== 5'd0 || sched_state !== 2'd0 || drained !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got wr=%b instr=%h cd=%b tot=%0d st=%0d dr=%b, required all zero",
                     core_wr_en, core_instr, clock_disable, pending_total, sched_state, drained);
        end else $display("mid-transfer reset ok");
`ifdef DISPATCH_STATS_EN
        vectors++;
        if (stat_dispatch !== '0) begin
            miscompares++;
            $display("FAIL stat_reset: got %h, required 0", stat_dispatch);
        end
`endif
        rst = 1'b0; in_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_tie_break();
        test_stall();
        test_idle_gate();
        test_flush();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
